uart_tx_arbiter: RTL and testbench

Shares one serial transmitter byte channel between several requesters. Grants are round-robin and packet-oriented, so bytes from different requesters never interleave within a packet. A burst limit bounds how long any requester can hold the line. It sits between host-side byte producers (command responders, debug taps, loopback paths) and the single UART transmitter. It uses the same valid/ready byte handshake as the UART receiver's `DataOut` / `DataOutValid` / `DataOutReady` interface.

---
 rtl/uart_tx_arbiter_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_select.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 94 +++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter shared definitions:
// FSM encoding and width helper.
package uart_tx_arbiter_pkg;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  // Minimum one bit so degenerate sizes still get a legal vector.
  function automatic int log2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Round-robin first-set search:
// lowest index at or above Start, wrapping.
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int Requesters = 4,
  parameter int IdxWidth   = log2(Requesters)
) (
  input  logic [Requesters-1:0] Request,
  input  logic [IdxWidth-1:0]   Start,
  output logic [IdxWidth-1:0]   Index,
  output logic                  Any
);

  logic [IdxWidth-1:0] cand;

  // Walk downward so the nearest candidate is written last.
  always_comb begin
    Index = '0;
    Any   = 1'b0;
    cand  = '0;
    for (int k = Requesters - 1; k >= 0; k--) begin
      cand = IdxWidth'((int'(Start) + k) % Requesters);
      if (Request[cand]) begin
        Index = cand;
        Any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-oriented round-robin arbiter
// feeding one UART transmitter byte channel.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int Width      = 8,
  parameter int Requesters = 4,
  parameter int MaxBurst   = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [Requesters*Width-1:0]   DataIn,
  input  logic [Requesters-1:0]         DataInValid,
  input  logic [Requesters-1:0]         DataInLast,
  output logic [Requesters-1:0]         DataInReady,
  output logic [Width-1:0]              DataOut,
  output logic                          DataOutValid,
  input  logic                          DataOutReady,
  output logic [Requesters-1:0]         Grant,
  output logic                          Busy
);

  localparam int IdxWidth = log2(Requesters);
  localparam int BCWidth  = log2(MaxBurst + 1);

  logic [0:0]          state;
  logic [IdxWidth-1:0] pointer;
  logic [IdxWidth-1:0] g;
  logic [BCWidth-1:0]  burstCount;

  logic [IdxWidth-1:0] selIdx;
  logic                selAny;
  logic [IdxWidth-1:0] nextPtr;
  logic                xfer;
  logic                lastBeat;
  logic [Width-1:0]    lane [Requesters];

  for (genvar i = 0; i < Requesters; i++) begin : gLane
    assign lane[i] = DataIn[i*Width +: Width];
  end

  rr_select #(
    .Requesters(Requesters),
    .IdxWidth  (IdxWidth)
  ) uSelect (
    .Request(DataInValid),
    .Start  (pointer),
    .Index  (selIdx),
    .Any    (selAny)
  );

  assign Busy = Reset && (state == StGrant);

  always_comb begin
    Grant        = '0;
    DataInReady  = '0;
    DataOut      = '0;
    DataOutValid = 1'b0;
    if (Busy) begin
      Grant[g]       = 1'b1;
      DataInReady[g] = DataOutReady;
      DataOut        = lane[g];
      DataOutValid   = DataInValid[g];
    end
  end

  assign xfer     = DataOutValid && DataOutReady;
  assign lastBeat = DataInLast[g] ||
                    (burstCount == BCWidth'(MaxBurst - 1));
  assign nextPtr  = (g == IdxWidth'(Requesters - 1)) ?
                    '0 : g + IdxWidth'(1);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= StIdle;
      pointer    <= '0;
      g          <= '0;
      burstCount <= '0;
    end else if (state == StIdle) begin
      if (selAny) begin
        state      <= StGrant;
        g          <= selIdx;
        burstCount <= '0;
      end
    end else if (xfer) begin
      burstCount <= burstCount + BCWidth'(1);
      if (lastBeat) begin
        state   <= StIdle;
        pointer <= nextPtr;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a
// packet-level reference model and per-cycle compare.
module tb_uart_tx_arbiter;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [R*W-1:0] din = '0;
  logic [R-1:0] vld = '0;
  logic [R-1:0] lst = '0;
  logic [R-1:0] rdyIn;
  logic [W-1:0] dout;
  logic dov;
  logic dor = 1'b1;
  logic [R-1:0] grant;
  logic busy;

  uart_tx_arbiter #(
    .Width(W), .Requesters(R), .MaxBurst(MB)
  ) dut (
    .Clock(clk), .Reset(rstn),
    .DataIn(din), .DataInValid(vld),
    .DataInLast(lst), .DataInReady(rdyIn),
    .DataOut(dout), .DataOutValid(dov),
    .DataOutReady(dor), .Grant(grant),
    .Busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit [8:0] q [R][$];
  bit [8:0] dummy;
  logic [R-1:0] acc = '0;
  int cyc = 0;
  logic [7:0] outLog[$];
  int cycLog[$];
  logic [R-1:0] grantLog[$];
  logic [R-1:0] lastGrant = '0;
  bit rstReq = 1'b0;
  bit rndRdy = 1'b0;
  int killAfter = 0;

  bit mBusy = 1'b0;
  int mOwner = 0;
  int mPtr = 0;
  int mCount = 0;

  logic [R-1:0] eG, eR;
  logic [W-1:0] eD;
  logic eV, eB;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: whole packets are owned by one requester, bounded by MB bytes.
  always @(posedge clk) begin
    if (!rstn) begin
      mBusy = 1'b0; mOwner = 0; mPtr = 0; mCount = 0;
    end else if (!mBusy) begin
      for (int k = 0; k < R; k++) begin
        if (!mBusy && vld[(mPtr + k) % R]) begin
          mBusy = 1'b1;
          mOwner = (mPtr + k) % R;
          mCount = 0;
        end
      end
    end else if (vld[mOwner] && dor) begin
      mCount++;
      if (lst[mOwner] || mCount == MB) begin
        mBusy = 1'b0;
        mPtr = (mOwner + 1) % R;
      end
    end
  end

  always @(negedge clk) begin
    eG = '0; eR = '0; eD = '0; eV = 1'b0; eB = 1'b0;
    if (rstn && mBusy) begin
      eG[mOwner] = 1'b1;
      eB = 1'b1;
      eD = din[mOwner*W +: W];
      eV = vld[mOwner];
      eR[mOwner] = dor;
    end
    check("cycle outputs", {grant, busy, dout, dov, rdyIn},
          {eG, eB, eD, eV, eR});
    acc = rdyIn & vld;
    if (dov && dor) begin
      outLog.push_back(dout);
      cycLog.push_back(cyc);
    end
    if (grant != lastGrant) grantLog.push_back(grant);
    lastGrant = grant;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < R; i++)
      if (acc[i] && q[i].size() > 0) dummy = q[i].pop_front();
    acc = '0;
    if (killAfter > 0 && outLog.size() >= killAfter) rstReq = 1'b0;
    rstn = rstReq;
    dor = rndRdy ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < R; i++) begin
      vld[i] = q[i].size() > 0;
      din[i*W +: W] = vld[i] ? q[i][0][7:0] : 8'h00;
      lst[i] = vld[i] ? q[i][0][8] : 1'b0;
    end
    #1;
  endtask

  task automatic addPkt(input int r, input int base, input int n);
    for (int k = 0; k < n; k++)
      q[r].push_back({k == n - 1, 8'(base + k)});
  endtask

  function automatic bit anyQ();
    for (int i = 0; i < R; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((anyQ() || mBusy) && n < 300) begin
      step();
      n++;
    end
    check({name, " drain in budget"}, 64'(n < 300), 64'd1);
    repeat (2) step();
  endtask

  task automatic clearLogs();
    outLog.delete();
    cycLog.delete();
    grantLog.delete();
  endtask

  task automatic checkLog(input string name, input logic [7:0] exp[$]);
    check({name, " byte count"}, 64'(outLog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s byte %0d", name, i),
            (i < outLog.size()) ? 64'(outLog[i]) : 64'hx,
            64'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp[$];
    logic [R-1:0] owners[$];
    int n;

    // Reset held with every requester valid.
    for (int r = 0; r < R; r++) addPkt(r, 8'h50 + r, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset grant", 64'(grant), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset inready", 64'(rdyIn), 64'd0);
      check("reset outvalid", 64'(dov), 64'd0);
    end
    rstReq = 1'b1;
    step();
    check("release grant", 64'(grant), 64'd0);
    step();
    check("first grant", 64'(grant), 64'b0001);
    check("first busy", 64'(busy), 64'd1);
    drain("t1");
    exp = '{8'h50, 8'h51, 8'h52, 8'h53};
    checkLog("t1", exp);

    // Two 3-byte packets from requesters 1 and 3.
    clearLogs();
    addPkt(1, 8'hA1, 3);
    addPkt(3, 8'hC1, 3);
    drain("t2");
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hC1, 8'hC2, 8'hC3};
    checkLog("t2", exp);
    check("t2 gap", 64'(cycLog[3] - cycLog[2]), 64'd2);
    check("t2 grant count", 64'(grantLog.size()), 64'd4);
    check("t2 grant a", 64'(grantLog[0]), 64'b0010);
    check("t2 grant b", 64'(grantLog[1]), 64'b0000);
    check("t2 grant c", 64'(grantLog[2]), 64'b1000);

    // Burst limit splits requester 2's 6-byte packet.
    clearLogs();
    addPkt(2, 8'hB1, 6);
    step();
    step();
    addPkt(0, 8'h01, 2);
    drain("t3");
    exp = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h01, 8'h02, 8'hB5, 8'hB6};
    checkLog("t3", exp);

    // Reset after two bytes of a 5-byte packet.
    clearLogs();
    addPkt(1, 8'hD1, 5);
    killAfter = 2;
    n = 0;
    while (rstn && n < 50) begin
      step();
      n++;
    end
    check("t5 reset reached", 64'(rstn), 64'd0);
    killAfter = 0;
    q[1].delete();
    addPkt(3, 8'hE1, 1);
    addPkt(0, 8'hF1, 1);
    step();
    step();
    check("t5 held grant", 64'(grant), 64'd0);
    rstReq = 1'b1;
    drain("t5");
    exp = '{8'hD1, 8'hD2, 8'hF1, 8'hE1};
    checkLog("t5", exp);

    // Random backpressure, all requesters streaming.
    clearLogs();
    rndRdy = 1'b1;
    addPkt(0, 8'h00, 4);
    addPkt(1, 8'h10, 4);
    addPkt(2, 8'h20, 4);
    addPkt(3, 8'h30, 4);
    addPkt(0, 8'h04, 4);
    drain("t4");
    rndRdy = 1'b0;
    exp.delete();
    for (int k = 0; k < 4; k++) exp.push_back(8'(8'h00 + k));
    for (int k = 0; k < 4; k++) exp.push_back(8'(8'h10 + k));
    for (int k = 0; k < 4; k++) exp.push_back(8'(8'h20 + k));
    for (int k = 0; k < 4; k++) exp.push_back(8'(8'h30 + k));
    for (int k = 0; k < 4; k++) exp.push_back(8'(8'h04 + k));
    checkLog("t4", exp);
    foreach (grantLog[i]) if (grantLog[i] != '0) owners.push_back(grantLog[i]);
    check("t4 owner count", 64'(owners.size()), 64'd5);
    check("t4 owner 0", 64'(owners[0]), 64'b0001);
    check("t4 owner 1", 64'(owners[1]), 64'b0010);
    check("t4 owner 2", 64'(owners[2]), 64'b0100);
    check("t4 owner 3", 64'(owners[3]), 64'b1000);
    check("t4 owner 4", 64'(owners[4]), 64'b0001);

    // Last flag on the burst-limit byte.
    clearLogs();
    addPkt(1, 8'h61, 4);
    addPkt(2, 8'h71, 1);
    addPkt(3, 8'h81, 1);
    drain("t6");
    exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h71, 8'h81};
    checkLog("t6", exp);
    check("t6 gap", 64'(cycLog[4] - cycLog[3]), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
